mem_stage_ctrl: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the writeback stage.
- Resolves BEQ/BNE and sequences loads/stores to a variable-latency data memory via a req/ready handshake.
- Stalls the upstream pipe while an access is outstanding.
- Contains the MEM/WB pipeline register bank feeding writeback.

---
 rtl/mips_pipe_pkg.sv | 25 ++
 rtl/mem_wb_reg.sv | 54 +++++
 rtl/mem_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
// Holds the memory FSM state encoding, MEM/WB control bundle and its bubble value.
package mips_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    // A bubble clears only the writeback controls; data fields keep their last value.
    localparam wb_ctrl_t WB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0};

    function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank: loads the current instruction or inserts a bubble.
// Load data is captured only on a completing load; otherwise it holds.
module mem_wb_reg #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  rdata_load,
    input  logic                  regwrite,
    input  logic                  memtoreg,
    input  logic [N-1:0]          alu_result,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [N-1:0]          rdata,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [N-1:0]          wb_read_data,
    output logic [N-1:0]          wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_write_reg
);
    import mips_pipe_pkg::*;

    wb_ctrl_t              ctrl_reg;
    logic [N-1:0]          read_data_reg;
    logic [N-1:0]          alu_result_reg;
    logic [REG_ADDR_W-1:0] write_reg_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg       <= WB_BUBBLE;
            read_data_reg  <= '0;
            alu_result_reg <= '0;
            write_reg_reg  <= '0;
        end else if (load) begin
            ctrl_reg.regwrite <= regwrite;
            ctrl_reg.memtoreg <= memtoreg;
            alu_result_reg    <= alu_result;
            write_reg_reg     <= write_reg;
            if (rdata_load) begin
                read_data_reg <= rdata;
            end
        end else begin
            ctrl_reg <= WB_BUBBLE;
        end
    end

    assign wb_regwrite   = ctrl_reg.regwrite;
    assign wb_memtoreg   = ctrl_reg.memtoreg;
    assign wb_read_data  = read_data_reg;
    assign wb_alu_result = alu_result_reg;
    assign wb_write_reg  = write_reg_reg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS MEM stage: branch resolution, data-memory req/ready sequencing, upstream stall, MEM/WB bank.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_beq,
    input  logic                  in_bne,
    input  logic                  in_memread,
    input  logic                  in_memwrite,
    input  logic                  in_memtoreg,
    input  logic                  in_regwrite,
    input  logic [N-1:0]          in_alu_result,
    input  logic                  in_alu_zero,
    input  logic [N-1:0]          in_branch_target,
    input  logic [N-1:0]          in_read_data2,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [N-1:0]          dmem_addr,
    output logic [N-1:0]          dmem_wdata,
    input  logic [N-1:0]          dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall,
    output logic                  pc_src,
    output logic [N-1:0]          branch_target,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [N-1:0]          wb_read_data,
    output logic [N-1:0]          wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_write_reg
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err,
    output logic [N-1:0]          misalign_addr
`endif
);
    import mips_pipe_pkg::*;

    mem_state_t state_reg;
    mem_state_t state_next;

    logic mem_op;
    logic read_op;
    logic misalign;
    logic access;
    logic wb_load;
    logic rdata_load;

    // Store wins over a simultaneous read, so a read only counts without memwrite.
    always_comb begin
        mem_op  = in_memread | in_memwrite;
        read_op = in_memread & ~in_memwrite;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = mem_op & (in_alu_result[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        access  = mem_op & ~misalign;
    end

    assign dmem_we       = in_memwrite;
    assign dmem_addr     = in_alu_result;
    assign dmem_wdata    = in_read_data2;
    assign branch_target = in_branch_target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (access && !dmem_ready) state_next = WAIT;
            WAIT:    if (dmem_ready)            state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Reset gates the request so an abandoned access drops off the bus at once.
    always_comb begin
        dmem_req   = reset & ((state_reg == WAIT) | access);
        stall      = dmem_req & ~dmem_ready;
        wb_load    = ~stall & ~misalign;
        rdata_load = read_op & dmem_req & dmem_ready;
        pc_src     = reset & ~stall & ~mem_op
                   & branch_taken(in_beq, in_bne, in_alu_zero);
    end

    mem_wb_reg #(
        .N          (N),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (wb_load),
        .rdata_load    (rdata_load),
        .regwrite      (in_regwrite),
        .memtoreg      (in_memtoreg),
        .alu_result    (in_alu_result),
        .write_reg     (in_write_reg),
        .rdata         (dmem_rdata),
        .wb_regwrite   (wb_regwrite),
        .wb_memtoreg   (wb_memtoreg),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic         misalign_err_reg;
    logic [N-1:0] misalign_addr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err_reg  <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            misalign_err_reg <= misalign & (state_reg == IDLE);
            if (misalign && state_reg == IDLE) begin
                misalign_addr_reg <= in_alu_result;
            end
        end
    end

    assign misalign_err  = misalign_err_reg;
    assign misalign_addr = misalign_addr_reg;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed, table-driven bench for mem_stage_ctrl plus hand sequences for reset and trap cases.
// Define MEM_MISALIGN_TRAP_EN to also exercise the misaligned-access trap.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_beq, in_bne, in_memread, in_memwrite, in_memtoreg, in_regwrite;
    logic [31:0] in_alu_result;
    logic        in_alu_zero;
    logic [31:0] in_branch_target, in_read_data2;
    logic [4:0]  in_write_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall, pc_src;
    logic [31:0] branch_target;
    logic        wb_regwrite, wb_memtoreg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
    logic [31:0] misalign_addr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.N(32), .REG_ADDR_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_beq           (in_beq),
        .in_bne           (in_bne),
        .in_memread       (in_memread),
        .in_memwrite      (in_memwrite),
        .in_memtoreg      (in_memtoreg),
        .in_regwrite      (in_regwrite),
        .in_alu_result    (in_alu_result),
        .in_alu_zero      (in_alu_zero),
        .in_branch_target (in_branch_target),
        .in_read_data2    (in_read_data2),
        .in_write_reg     (in_write_reg),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .stall            (stall),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .wb_regwrite      (wb_regwrite),
        .wb_memtoreg      (wb_memtoreg),
        .wb_read_data     (wb_read_data),
        .wb_alu_result    (wb_alu_result),
        .wb_write_reg     (wb_write_reg)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_err     (misalign_err),
        .misalign_addr    (misalign_addr)
`endif
    );

    // ctl bits: {beq, bne, memread, memwrite, memtoreg, regwrite, alu_zero}
    localparam logic [6:0] C_NOP     = 7'b0000000;
    localparam logic [6:0] C_ALU     = 7'b0000010;
    localparam logic [6:0] C_LOAD    = 7'b0010110;
    localparam logic [6:0] C_STORE   = 7'b0001000;
    localparam logic [6:0] C_BEQZ    = 7'b1000001;
    localparam logic [6:0] C_BNEZ    = 7'b0100001;
    localparam logic [6:0] C_BNE     = 7'b0100000;
    localparam logic [6:0] C_LOADBEQ = 7'b1010111;
    localparam logic [6:0] C_LDST    = 7'b0011000;

    // exp flags: {dmem_req, stall, pc_src, wb_regwrite, wb_memtoreg}
    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] alu;
        logic [31:0] tgt;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        logic        ready;
        logic [4:0]  exp_flags;
        logic [31:0] exp_rd;
        logic [31:0] exp_alu;
        logic [4:0]  exp_wreg;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [31:0] alu, input logic [31:0] tgt,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] wreg,
                         input logic ready);
        {in_beq, in_bne, in_memread, in_memwrite, in_memtoreg, in_regwrite, in_alu_zero} = ctl;
        in_alu_result    = alu;
        in_branch_target = tgt;
        in_read_data2    = wd;
        dmem_rdata       = rdata;
        in_write_reg     = wreg;
        dmem_ready       = ready;
    endtask

    initial begin
        //           ctl        alu       tgt       wd        rdata         wreg   rdy  flags     exp_rd        exp_alu   wreg
        vecs[0]  = '{C_ALU,     32'h55,   32'h0,    32'h0,    32'h0,        5'd3,  1'b0, 5'b00010, 32'h0,        32'h55,   5'd3};
        vecs[1]  = '{C_LOAD,    32'h10,   32'h0,    32'h0,    32'h0BADF00D, 5'd8,  1'b0, 5'b11000, 32'h0,        32'h55,   5'd3};
        vecs[2]  = '{C_LOAD,    32'h10,   32'h0,    32'h0,    32'h0BADF00D, 5'd8,  1'b0, 5'b11000, 32'h0,        32'h55,   5'd3};
        vecs[3]  = '{C_LOAD,    32'h10,   32'h0,    32'h0,    32'h0BADF00D, 5'd8,  1'b0, 5'b11000, 32'h0,        32'h55,   5'd3};
        vecs[4]  = '{C_LOAD,    32'h10,   32'h0,    32'h0,    32'hDEADBEEF, 5'd8,  1'b1, 5'b10011, 32'hDEADBEEF, 32'h10,   5'd8};
        vecs[5]  = '{C_STORE,   32'h20,   32'h0,    32'h1234, 32'hCAFE0000, 5'd0,  1'b1, 5'b10000, 32'hDEADBEEF, 32'h20,   5'd0};
        vecs[6]  = '{C_NOP,     32'h0,    32'h0,    32'h0,    32'h0,        5'd0,  1'b0, 5'b00000, 32'hDEADBEEF, 32'h0,    5'd0};
        vecs[7]  = '{C_BEQZ,    32'h0,    32'h400,  32'h0,    32'h0,        5'd0,  1'b0, 5'b00100, 32'hDEADBEEF, 32'h0,    5'd0};
        vecs[8]  = '{C_BNEZ,    32'h0,    32'h800,  32'h0,    32'h0,        5'd0,  1'b0, 5'b00000, 32'hDEADBEEF, 32'h0,    5'd0};
        vecs[9]  = '{C_BNE,     32'h4,    32'hC00,  32'h0,    32'h0,        5'd0,  1'b0, 5'b00100, 32'hDEADBEEF, 32'h4,    5'd0};
        vecs[10] = '{C_LOAD,    32'h40,   32'h0,    32'h0,    32'h0,        5'd9,  1'b0, 5'b11000, 32'hDEADBEEF, 32'h4,    5'd0};
        vecs[11] = '{C_LOAD,    32'h40,   32'h0,    32'h0,    32'h11111111, 5'd9,  1'b1, 5'b10011, 32'h11111111, 32'h40,   5'd9};
        vecs[12] = '{C_LOAD,    32'h44,   32'h0,    32'h0,    32'h0,        5'd10, 1'b0, 5'b11000, 32'h11111111, 32'h40,   5'd9};
        vecs[13] = '{C_LOAD,    32'h44,   32'h0,    32'h0,    32'h22222222, 5'd10, 1'b1, 5'b10011, 32'h22222222, 32'h44,   5'd10};
        vecs[14] = '{C_NOP,     32'h0,    32'h0,    32'h0,    32'h0,        5'd0,  1'b0, 5'b00000, 32'h22222222, 32'h0,    5'd0};
        vecs[15] = '{C_LOADBEQ, 32'h48,   32'h500,  32'h0,    32'h33333333, 5'd11, 1'b1, 5'b10011, 32'h33333333, 32'h48,   5'd11};
        vecs[16] = '{C_LDST,    32'h4C,   32'h0,    32'hABCD, 32'h44444444, 5'd0,  1'b1, 5'b10000, 32'h33333333, 32'h4C,   5'd0};
        vecs[17] = '{C_LOADBEQ, 32'h50,   32'h500,  32'h0,    32'h0,        5'd12, 1'b0, 5'b11000, 32'h33333333, 32'h4C,   5'd0};
        vecs[18] = '{C_LOADBEQ, 32'h50,   32'h500,  32'h0,    32'h55555555, 5'd12, 1'b1, 5'b10011, 32'h55555555, 32'h50,   5'd12};

        reset = 1'b0;
        drive(C_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, dmem_req},    32'h0);
        chk("rst_stall", {31'b0, stall},       32'h0);
        chk("rst_pcsrc", {31'b0, pc_src},      32'h0);
        chk("rst_wb_rw", {31'b0, wb_regwrite}, 32'h0);
        chk("rst_wb_rd", wb_read_data,         32'h0);
        chk("rst_wb_alu", wb_alu_result,       32'h0);
        chk("rst_wb_wreg", {27'b0, wb_write_reg}, 32'h0);
        reset = 1'b1;
        $display("reset released");

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].alu, vecs[i].tgt, vecs[i].wd, vecs[i].rdata,
                  vecs[i].wreg, vecs[i].ready);
            #2;
            chk($sformatf("v%0d_req", i),   {31'b0, dmem_req}, {31'b0, vecs[i].exp_flags[4]});
            chk($sformatf("v%0d_stall", i), {31'b0, stall},    {31'b0, vecs[i].exp_flags[3]});
            chk($sformatf("v%0d_pcsrc", i), {31'b0, pc_src},   {31'b0, vecs[i].exp_flags[2]});
            chk($sformatf("v%0d_we", i),    {31'b0, dmem_we},  {31'b0, vecs[i].ctl[3]});
            chk($sformatf("v%0d_addr", i),  dmem_addr,         vecs[i].alu);
            chk($sformatf("v%0d_wdata", i), dmem_wdata,        vecs[i].wd);
            chk($sformatf("v%0d_btgt", i),  branch_target,     vecs[i].tgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb_rw", i),   {31'b0, wb_regwrite}, {31'b0, vecs[i].exp_flags[1]});
            chk($sformatf("v%0d_wb_mtr", i),  {31'b0, wb_memtoreg}, {31'b0, vecs[i].exp_flags[0]});
            chk($sformatf("v%0d_wb_rd", i),   wb_read_data,  vecs[i].exp_rd);
            chk($sformatf("v%0d_wb_alu", i),  wb_alu_result, vecs[i].exp_alu);
            chk($sformatf("v%0d_wb_wreg", i), {27'b0, wb_write_reg}, {27'b0, vecs[i].exp_wreg});
            $display("vec %0d ctl=%07b addr=0x%08h rdy=%0b -> req=%0b stall=%0b pc_src=%0b wb_rw=%0b wb_rd=0x%08h",
                     i, vecs[i].ctl, vecs[i].alu, vecs[i].ready, vecs[i].exp_flags[4],
                     vecs[i].exp_flags[3], vecs[i].exp_flags[2], wb_regwrite, wb_read_data);
        end

`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        drive(C_LOAD, 32'h13, 32'h0, 32'h0, 32'h0, 5'd14, 1'b0);
        #2;
        chk("mis_req",   {31'b0, dmem_req}, 32'h0);
        chk("mis_stall", {31'b0, stall},    32'h0);
        @(posedge clk);
        #1;
        chk("mis_err",   {31'b0, misalign_err}, 32'h1);
        chk("mis_addr",  misalign_addr,         32'h13);
        chk("mis_wb_rw", {31'b0, wb_regwrite},  32'h0);
        @(negedge clk);
        drive(C_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("mis_err_pulse", {31'b0, misalign_err}, 32'h0);
        chk("mis_addr_hold", misalign_addr,         32'h13);
        $display("misaligned load at 0x13 trapped");
`endif

        // Reset arriving while an access is outstanding abandons it.
        @(negedge clk);
        drive(C_LOAD, 32'h60, 32'h0, 32'h0, 32'h0, 5'd13, 1'b0);
        @(posedge clk);
        #1;
        chk("mw_wait_req",   {31'b0, dmem_req}, 32'h1);
        chk("mw_wait_stall", {31'b0, stall},    32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mw_rst_req",   {31'b0, dmem_req},    32'h0);
        chk("mw_rst_stall", {31'b0, stall},       32'h0);
        chk("mw_rst_wb_rw", {31'b0, wb_regwrite}, 32'h0);
        chk("mw_rst_wb_rd", wb_read_data,         32'h0);
        chk("mw_rst_wb_alu", wb_alu_result,       32'h0);
        chk("mw_rst_wb_wreg", {27'b0, wb_write_reg}, 32'h0);
        drive(C_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("mw_rel_req",   {31'b0, dmem_req}, 32'h0);
        chk("mw_rel_stall", {31'b0, stall},    32'h0);
        @(posedge clk);
        #1;
        chk("mw_rel_wb_rw", {31'b0, wb_regwrite}, 32'h0);
        chk("mw_rel_req2",  {31'b0, dmem_req},    32'h0);
        $display("reset mid-wait abandoned access");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
